// File: rtl/bk_sum_stage.sv
// Brent-Kung sum stage: forms sum/carry-out from bitwise propagates and prefix
// generates, then holds results in a 2-entry FIFO behind a valid/ready handshake.
module bk_sum_stage #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] P_bits,
    input  logic [N-1:0] G_grp,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic [1:0]   dbg_count_o
);

    // Handshake: a beat moves when valid and ready are both high at a rising
    // edge; in_ready depends only on occupancy, never on out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [N:0] head_q, head_d;
    logic [N:0] tail_q, tail_d;
    logic [N:0] result;
    logic       push;
    logic       pop;

    // Bit i of the sum uses the group generate of bits below it; bit 0 uses raw cin.
    always_comb begin
        result = {G_grp[N-1], P_bits ^ {G_grp[N-2:0], cin}};
    end

    always_comb begin
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (!push && pop) state_d = EMPTY;
            end
            TWO:   if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    // Storage only loads on an accepted beat, so idle X inputs never reach state.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        unique case (state_q)
            EMPTY: if (push) head_d = result;
            ONE: begin
                if (push && pop) head_d = result;
                else if (push)   tail_d = result;
            end
            TWO:   if (pop) head_d = tail_q;
            default: begin
                head_d = head_q;
                tail_d = tail_q;
            end
        endcase
    end

    always_comb begin
        in_ready    = (state_q != TWO);
        out_valid   = (state_q != EMPTY);
        sum         = head_q[N-1:0];
        cout        = head_q[N];
        dbg_count_o = state_q;
    end

endmodule

// File: tb/tb_bk_sum_stage.sv
// Bench for bk_sum_stage: directed and random beats checked against an
// arithmetic adder model feeding a FIFO queue of expected results.
module tb_bk_sum_stage;
    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] P_bits;
    logic [N-1:0] G_grp;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic [1:0]   dbg_count_o;

    bk_sum_stage #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .P_bits     (P_bits),
        .G_grp      (G_grp),
        .cin        (cin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sum        (sum),
        .cout       (cout),
        .dbg_count_o(dbg_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [N:0] exp_q[$];
    logic [N:0] cur_res;
    logic [N:0] last_out;
    logic       held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Carry out of bit i = bit i+1 of the arithmetic sum of the low i+1 bits.
    function automatic logic [N-1:0] gen_g(input int a, input int b, input int ci);
        logic [N-1:0] g;
        for (int i = 0; i < N; i++) begin
            int m;
            m = (1 << (i + 1)) - 1;
            g[i] = ((((a & m) + (b & m) + ci) >> (i + 1)) & 1) == 1;
        end
        return g;
    endfunction

    task automatic drive_ops(input logic v, input int a, input int b, input int ci,
                             input logic ordy);
        in_valid  = v;
        out_ready = ordy;
        if (v) begin
            P_bits  = N'(a ^ b);
            G_grp   = gen_g(a, b, ci);
            cin     = ci[0];
            cur_res = (N + 1)'(a + b + ci);
        end else begin
            P_bits = 'x;
            G_grp  = 'x;
            cin    = 1'bx;
        end
    endtask

    task automatic drive_raw(input logic [N-1:0] p, input logic [N-1:0] g, input logic ci,
                             input logic [N:0] exp_res, input logic ordy);
        in_valid  = 1'b1;
        out_ready = ordy;
        P_bits    = p;
        G_grp     = g;
        cin       = ci;
        cur_res   = exp_res;
    endtask

    task automatic tick(input string tag);
        logic m_push, m_pop;
        m_push = (in_valid === 1'b1) && !rst && (exp_q.size() != 2);
        m_pop  = (out_ready === 1'b1) && !rst && (exp_q.size() != 0);
        held   = (in_valid === 1'b1) && !m_push;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            last_out = '0;
        end else begin
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(cur_res);
        end
        if (exp_q.size() != 0) last_out = exp_q[0];
        @(negedge clk);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_q.size() != 0));
        check({tag, ".in_ready"},  32'(in_ready),  32'(exp_q.size() != 2));
        check({tag, ".count"},     32'(dbg_count_o), 32'(exp_q.size()));
        check({tag, ".result"},    32'({cout, sum}), 32'(last_out));
    endtask

    initial begin
        held     = 1'b0;
        last_out = '0;
        cur_res  = '0;
        rst      = 1'b1;
        drive_ops(1'b0, 0, 0, 0, 1'b0);
        tick("reset");
        tick("reset2");
        rst = 1'b0;
        tick("idle");

        // Basic add 13+7 and carry ripple 31+1.
        drive_ops(1'b1, 13, 7, 0, 1'b1);
        tick("add13_7");
        check("add13_7.sum20", 32'({cout, sum}), 32'd20);
        drive_ops(1'b1, 31, 1, 0, 1'b1);
        tick("add31_1");
        check("add31_1.cout", 32'({cout, sum}), 32'h20);
        drive_raw(5'b00001, 5'b00000, 1'b1, '0, 1'b1);
        tick("cin_path");
        drive_ops(1'b0, 0, 0, 0, 1'b1);
        tick("drain0");
        tick("hold_after_empty");

        // Back-pressure: three beats with out_ready low.
        drive_ops(1'b1, 13, 7, 0, 1'b0);
        tick("bp1");
        drive_ops(1'b1, 0, 0, 0, 1'b0);
        tick("bp2");
        drive_ops(1'b1, 3, 4, 0, 1'b0);
        tick("bp3_held");
        tick("bp3_held2");
        check("bp.head20", 32'(sum), 32'd20);
        out_ready = 1'b1;
        tick("bp_pop1");
        tick("bp_pop2");
        drive_ops(1'b0, 0, 0, 0, 1'b1);
        tick("bp_pop3");
        tick("bp_empty");

        // Streaming at one beat per cycle.
        for (int i = 0; i < 8; i++) begin
            drive_ops(1'b1, i * 3 + 1, 31 - i * 2, i & 1, 1'b1);
            tick("stream");
        end
        drive_ops(1'b0, 0, 0, 0, 1'b1);
        tick("stream_end");

        // Push+pop at ONE, then pop at TWO.
        drive_ops(1'b1, 5, 6, 1, 1'b0);
        tick("one_fill");
        drive_ops(1'b1, 9, 9, 0, 1'b1);
        tick("one_pushpop");
        drive_ops(1'b1, 17, 2, 1, 1'b0);
        tick("two_fill");
        drive_ops(1'b0, 0, 0, 0, 1'b1);
        tick("two_pop");
        tick("one_pop");

        // Reset while full, with handshake inputs active.
        drive_ops(1'b1, 11, 12, 0, 1'b0);
        tick("rst_fill1");
        drive_ops(1'b1, 21, 8, 1, 1'b0);
        tick("rst_fill2");
        rst = 1'b1;
        drive_ops(1'b1, 1, 2, 0, 1'b1);
        tick("rst_mid");
        check("rst_mid.sum0", 32'({cout, sum}), 32'd0);
        rst = 1'b0;
        drive_ops(1'b0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) tick("post_rst");

        // Random traffic; upstream holds data while a beat is stalled.
        for (int i = 0; i < 400; i++) begin
            if (!held)
                drive_ops(1'($urandom_range(0, 1)), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 1),
                          1'($urandom_range(0, 1)));
            else
                out_ready = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
